// File: rtl/id_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a DEPTH-entry
// output queue with valid/ready on both sides. Define ID_DECODE_MEXT_EN to decode the M extension.
module id_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      inst_type,
  output logic [4:0]      alu_op,
  output logic [2:0]      src_tag,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7;

  localparam logic [4:0] ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_SLL = 5'd3, ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLTU = 5'd5, ALU_XOR = 5'd6, ALU_SRL = 5'd7, ALU_SRA = 5'd8;
  localparam logic [4:0] ALU_OR = 5'd9, ALU_AND = 5'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      inst_type;
    logic [4:0]      alu_op;
    logic [2:0]      src_tag;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            illegal;
  } entry_t;

  function automatic logic [4:0] base_alu(input logic [2:0] f);
    case (f)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] f_rs1, f_rs2, f_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f_rd   = inst[11:7];
  assign f3     = inst[14:12];
  assign f_rs1  = inst[19:15];
  assign f_rs2  = inst[24:20];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  entry_t dec;
  logic   bad;

  // Each format fills only the fields it uses; anything unrecognised collapses to a bare illegal entry.
  always_comb begin
    bad = 1'b0;
    dec = '0;
    dec.pc = pc_in;
    case (opcode)
      OP_R: begin
        dec.inst_type = T_R;
        dec.src_tag   = 3'b110;
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec.reg_write = 1'b1;
        case (f7)
          7'b0000000: dec.alu_op = base_alu(f3);
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
            else                   bad = 1'b1;
          end
`ifdef ID_DECODE_MEXT_EN
          7'b0000001: dec.alu_op = {2'b10, f3};
`endif
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.inst_type = T_I;
        dec.src_tag   = 3'b011;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec.imm       = sext(imm_i);
        dec.reg_write = 1'b1;
        dec.alu_op    = base_alu(f3);
        if (f3 == 3'b001 && f7 != 7'b0000000) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec.alu_op = ALU_SRA;
          else if (f7 != 7'b0000000) bad = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.inst_type = T_I;
        dec.alu_op    = ALU_ADD;
        dec.src_tag   = 3'b011;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec.imm       = sext(imm_i);
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.inst_type = T_S;
        dec.alu_op    = ALU_ADD;
        dec.src_tag   = 3'b111;
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.funct3    = f3;
        dec.imm       = sext(imm_s);
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.inst_type = T_B;
        dec.alu_op    = ALU_SUB;
        dec.src_tag   = 3'b110;
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.funct3    = f3;
        dec.imm       = sext(imm_b);
        dec.branch    = 1'b1;
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.inst_type = T_U;
        dec.alu_op    = ALU_ADD;
        dec.src_tag   = 3'b001;
        dec.rd        = f_rd;
        dec.imm       = sext(imm_u);
        dec.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec.inst_type = T_J;
        dec.alu_op    = ALU_ADD;
        dec.src_tag   = 3'b001;
        dec.rd        = f_rd;
        dec.imm       = sext(imm_j);
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.inst_type = T_I;
        dec.alu_op    = ALU_ADD;
        dec.src_tag   = 3'b011;
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.funct3    = f3;
        dec.imm       = sext(imm_i);
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec = '0;
      dec.pc        = pc_in;
      dec.inst_type = T_ILL;
      dec.illegal   = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic            in_ready_q;
  logic            push, pop;

  assign in_ready  = in_ready_q;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_ONE;
    else if (!push && pop) count_next = count - CNT_ONE;
  end

  // in_ready is registered from the next count so out_ready never reaches it combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_next;
      in_ready_q <= (count_next != FULL_CNT);
    end
  end

  entry_t head;
  assign head      = mem[rd_ptr];
  assign pc_out    = head.pc;
  assign inst_type = head.inst_type;
  assign alu_op    = head.alu_op;
  assign src_tag   = head.src_tag;
  assign imm       = head.imm;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign funct3    = head.funct3;
  assign reg_write = head.reg_write;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign branch    = head.branch;
  assign jump      = head.jump;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: two instances (DEPTH 2 and 4) checked against
// a format-table decode model; directed checks on the DEPTH 2 lane, random stream on both.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  itype;
    logic [4:0]  alu;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, mr, mw, br, jp, il;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_s [2];
  logic        out_ready_s[2];
  logic        flush_s    [2];
  logic [31:0] inst_s     [2];
  logic [31:0] pc_s       [2];

  logic        in_ready_w [2];
  logic        out_valid_w[2];
  logic [31:0] pc_out_w   [2];
  logic [31:0] imm_w      [2];
  logic [2:0]  type_w     [2];
  logic [2:0]  src_w      [2];
  logic [2:0]  f3_w       [2];
  logic [4:0]  alu_w      [2];
  logic [4:0]  rs1_w      [2];
  logic [4:0]  rs2_w      [2];
  logic [4:0]  rd_w       [2];
  logic        rw_w[2], mr_w[2], mw_w[2], br_w[2], jp_w[2], il_w[2];

  int n_checks = 0;
  int n_fail   = 0;
  int remaining[2];
  bit acc[2];
  logic [31:0] pc_ctr = 32'h0000_1000;

  logic [4:0] r_ops [logic [9:0]];
  logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h67};

  // Reference decode: pick a format from the opcode, then pull fields and the immediate by format.
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    bit ok = 1'b1;
    int fmt = 7;
    e = '0;
    case (op)
      7'h33: begin
        fmt = 0; e.src = 3'b110; e.rw = 1'b1;
        if (r_ops.exists({f7, f3})) e.alu = r_ops[{f7, f3}]; else ok = 1'b0;
      end
      7'h13: begin
        fmt = 1; e.src = 3'b011; e.rw = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if ((f7 == 7'h00 || f7 == 7'h20) && r_ops.exists({f7, f3})) e.alu = r_ops[{f7, f3}];
          else ok = 1'b0;
        end else e.alu = r_ops[{7'h00, f3}];
      end
      7'h03: begin fmt = 1; e.src = 3'b011; e.alu = 5'd1; e.mr = 1'b1; e.rw = 1'b1; end
      7'h23: begin fmt = 2; e.src = 3'b111; e.alu = 5'd1; e.mw = 1'b1; end
      7'h63: begin
        fmt = 3; e.src = 3'b110; e.alu = 5'd2; e.br = 1'b1;
        if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
      end
      7'h37, 7'h17: begin fmt = 4; e.src = 3'b001; e.alu = 5'd1; e.rw = 1'b1; end
      7'h6f: begin fmt = 5; e.src = 3'b001; e.alu = 5'd1; e.jp = 1'b1; e.rw = 1'b1; end
      7'h67: begin fmt = 1; e.src = 3'b011; e.alu = 5'd1; e.jp = 1'b1; e.rw = 1'b1; end
      default: ok = 1'b0;
    endcase
    e.itype = 3'(fmt);
    if (fmt <= 3) begin e.rs1 = w[19:15]; e.f3 = f3; end
    if (fmt == 0 || fmt == 2 || fmt == 3) e.rs2 = w[24:20];
    if (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) e.rd = w[11:7];
    case (fmt)
      1: e.imm = 32'($signed(w) >>> 20);
      2: e.imm = (32'($signed(w) >>> 20) & 32'hFFFF_FFE0) | 32'(w[11:7]);
      3: e.imm = (32'($signed(w) >>> 19) & 32'hFFFF_F000) | (32'(w[7]) << 11)
                 | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      4: e.imm = w & 32'hFFFF_F000;
      5: e.imm = (32'($signed(w) >>> 11) & 32'hFFF0_0000) | (32'(w[19:12]) << 12)
                 | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: e.imm = '0;
    endcase
    if (!ok) begin
      e = '0;
      e.itype = 3'd7;
      e.il = 1'b1;
    end
    if (e.rd == 5'd0) e.rw = 1'b0;
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    int sel = $urandom_range(0, 11);
    if (sel < 9) w[6:0] = ops[sel];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D = 2 << g;
    exp_t q[$];
    exp_t act;
    int   sz;

    id_decode_stage #(.XLEN(32), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush_s[g]),
      .in_valid(in_valid_s[g]), .in_ready(in_ready_w[g]),
      .inst(inst_s[g]), .pc_in(pc_s[g]),
      .out_valid(out_valid_w[g]), .out_ready(out_ready_s[g]),
      .pc_out(pc_out_w[g]), .inst_type(type_w[g]), .alu_op(alu_w[g]),
      .src_tag(src_w[g]), .imm(imm_w[g]), .rs1(rs1_w[g]), .rs2(rs2_w[g]),
      .rd(rd_w[g]), .funct3(f3_w[g]), .reg_write(rw_w[g]), .mem_read(mr_w[g]),
      .mem_write(mw_w[g]), .branch(br_w[g]), .jump(jp_w[g]), .illegal(il_w[g])
    );

    // Monitor: compare handshake state and head payload to the model, then apply this cycle's edge.
    always @(negedge clk) begin
      if (!rst) q.delete();
      else begin
        sz = q.size();
        n_checks += 2;
        if (in_ready_w[g] !== (sz < D)) begin
          n_fail++;
          $display("[TB] FAIL lane%0d in_ready: got %b, want %b", g, in_ready_w[g], sz < D);
        end
        if (out_valid_w[g] !== (sz != 0)) begin
          n_fail++;
          $display("[TB] FAIL lane%0d out_valid: got %b, want %b", g, out_valid_w[g], sz != 0);
        end
        if (sz != 0) begin
          act.pc = pc_out_w[g];  act.itype = type_w[g]; act.alu = alu_w[g];
          act.src = src_w[g];    act.imm = imm_w[g];    act.rs1 = rs1_w[g];
          act.rs2 = rs2_w[g];    act.rd = rd_w[g];      act.f3 = f3_w[g];
          act.rw = rw_w[g];      act.mr = mr_w[g];      act.mw = mw_w[g];
          act.br = br_w[g];      act.jp = jp_w[g];      act.il = il_w[g];
          n_checks++;
          if (act !== q[0]) begin
            n_fail++;
            $display("[TB] FAIL lane%0d head_entry: got %h, want %h", g, act, q[0]);
          end
        end
        if (flush_s[g]) q.delete();
        else begin
          if (out_ready_s[g] && sz != 0) void'(q.pop_front());
          if (in_valid_s[g] && sz < D) q.push_back(ref_decode(inst_s[g], pc_s[g]));
        end
      end
      remaining[g] = q.size();
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Offers one instruction on lane 0 and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] w);
    int waited = 0;
    inst_s[0] = w;
    pc_s[0] = pc_ctr;
    pc_ctr += 32'd4;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    while (!in_ready_w[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_w[0]) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got in_ready 0, want 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pc_a, pc_b, pc_c;
    r_ops[{7'h00, 3'd0}] = 5'd1;  r_ops[{7'h00, 3'd1}] = 5'd3;
    r_ops[{7'h00, 3'd2}] = 5'd4;  r_ops[{7'h00, 3'd3}] = 5'd5;
    r_ops[{7'h00, 3'd4}] = 5'd6;  r_ops[{7'h00, 3'd5}] = 5'd7;
    r_ops[{7'h00, 3'd6}] = 5'd9;  r_ops[{7'h00, 3'd7}] = 5'd10;
    r_ops[{7'h20, 3'd0}] = 5'd2;  r_ops[{7'h20, 3'd5}] = 5'd8;
`ifdef ID_DECODE_MEXT_EN
    for (int f = 0; f < 8; f++) r_ops[{7'h01, 3'(f)}] = 5'(16 + f);
`endif
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b1; flush_s[k] = 1'b0;
      inst_s[k] = '0; pc_s[k] = '0;
    end

    #12;
    checkOutput("reset_out_valid", 32'(out_valid_w[0]), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready_w[0]), 32'd1);
    checkOutput("reset_pc_out", pc_out_w[0], 32'd0);
    checkOutput("reset_imm", imm_w[0], 32'd0);
    checkOutput("reset_alu_op", 32'(alu_w[0]), 32'd0);
    checkOutput("reset_in_ready_d4", 32'(in_ready_w[1]), 32'd1);
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(32'hFFF0_0093);
    checkOutput("addi_out_valid", 32'(out_valid_w[0]), 32'd1);
    checkOutput("addi_type", 32'(type_w[0]), 32'd1);
    checkOutput("addi_alu", 32'(alu_w[0]), 32'd1);
    checkOutput("addi_imm", imm_w[0], 32'hFFFF_FFFF);
    checkOutput("addi_rd", 32'(rd_w[0]), 32'd1);
    checkOutput("addi_src", 32'(src_w[0]), 32'b011);
    checkOutput("addi_reg_write", 32'(rw_w[0]), 32'd1);

    applyStimulus(32'h4020_81B3);
    checkOutput("sub_alu", 32'(alu_w[0]), 32'd2);
    checkOutput("sub_rs1", 32'(rs1_w[0]), 32'd1);
    checkOutput("sub_rs2", 32'(rs2_w[0]), 32'd2);
    checkOutput("sub_rd", 32'(rd_w[0]), 32'd3);
    checkOutput("sub_src", 32'(src_w[0]), 32'b110);

    applyStimulus(32'h0020_A423);
    checkOutput("sw_type", 32'(type_w[0]), 32'd2);
    checkOutput("sw_imm", imm_w[0], 32'd8);
    checkOutput("sw_mem_write", 32'(mw_w[0]), 32'd1);
    checkOutput("sw_reg_write", 32'(rw_w[0]), 32'd0);

    applyStimulus(32'h0273_02B3);
`ifdef ID_DECODE_MEXT_EN
    checkOutput("mul_alu", 32'(alu_w[0]), 32'd16);
    checkOutput("mul_illegal", 32'(il_w[0]), 32'd0);
`else
    checkOutput("mul_type", 32'(type_w[0]), 32'd7);
    checkOutput("mul_illegal", 32'(il_w[0]), 32'd1);
    checkOutput("mul_reg_write", 32'(rw_w[0]), 32'd0);
`endif

    // Backpressure: two accepts fill DEPTH 2, the third waits with the head held stable.
    repeat (2) @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    pc_a = pc_ctr;
    applyStimulus(32'h0011_0113);
    pc_b = pc_ctr;
    applyStimulus(32'h0041_8193);
    checkOutput("full_in_ready", 32'(in_ready_w[0]), 32'd0);
    pc_c = pc_ctr;
    inst_s[0] = 32'h0062_02B3;
    pc_s[0] = pc_c;
    pc_ctr += 32'd4;
    in_valid_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_in_ready", 32'(in_ready_w[0]), 32'd0);
    checkOutput("stall_head_pc", pc_out_w[0], pc_a);
    checkOutput("stall_head_imm", imm_w[0], 32'd1);
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_head_pc_b", pc_out_w[0], pc_b);
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    checkOutput("release_head_pc_c", pc_out_w[0], pc_c);
    checkOutput("release_out_valid", 32'(out_valid_w[0]), 32'd1);

    // Flush with a full queue and then with one entry; the offered word must be dropped.
    repeat (2) @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    applyStimulus(32'h0000_0013);
    applyStimulus(32'h0000_0037);
    flush_s[0] = 1'b1;
    inst_s[0] = 32'h0010_0093;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    flush_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    checkOutput("flush_full_out_valid", 32'(out_valid_w[0]), 32'd0);
    checkOutput("flush_full_in_ready", 32'(in_ready_w[0]), 32'd1);
    applyStimulus(32'h0050_0293);
    flush_s[0] = 1'b1;
    inst_s[0] = 32'h0070_0393;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    flush_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    checkOutput("flush_one_out_valid", 32'(out_valid_w[0]), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("flush_dropped_out_valid", 32'(out_valid_w[0]), 32'd0);

    // Asynchronous reset mid-cycle empties the queue at once.
    applyStimulus(32'h00A0_0513);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid_w[0]), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready_w[0]), 32'd1);
    checkOutput("midreset_pc_out", pc_out_w[0], 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Random stream on both lanes; an offer is held until accepted or flushed.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) acc[k] = in_valid_s[k] && (in_ready_w[k] || flush_s[k]);
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        flush_s[k] = ($urandom_range(0, 63) == 0);
        out_ready_s[k] = ($urandom_range(0, 2) != 0);
        if (!in_valid_s[k] || acc[k]) begin
          in_valid_s[k] = ($urandom_range(0, 3) != 0);
          inst_s[k] = rand_inst();
          pc_s[k] = $urandom & 32'hFFFF_FFFC;
        end
      end
    end

    for (int k = 0; k < 2; k++) begin
      in_valid_s[k] = 1'b0; flush_s[k] = 1'b0; out_ready_s[k] = 1'b1;
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("drain_model_lane0", 32'(remaining[0]), 32'd0);
    checkOutput("drain_model_lane1", 32'(remaining[1]), 32'd0);
    checkOutput("drain_out_valid_lane1", 32'(out_valid_w[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered, parametrised RV32I instruction-decode stage with a valid/ready handshake on both sides and a DEPTH-entry output queue. It sits between the fetch stage and the id/ex register-read logic. It covers every RV32I format (R, I-ALU incl. shifts, load, S, B, LUI, AUIPC, JAL, JALR) and flags unknown encodings as illegal. A pipeline flush empties the queue.

## Interface
Parameters:
- XLEN, 32, datapath and immediate width (>= 32)
- DEPTH, 2, output queue entries (power of two, >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous queue clear
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept
- inst  in  32  instruction word
- pc_in  in  XLEN  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  id/ex consumes head
- pc_out  out  XLEN  head pc
- inst_type  out  3  R=0, I=1, S=2, B=3, U=4, J=5, ILLEGAL=7
- alu_op  out  5  NOP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10; MUL..REMU=16..23
- src_tag  out  3  bit2 rs2 read, bit1 rs1 read, bit0 imm used
- imm  out  XLEN  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- funct3  out  3  raw funct3 (branch/memory size)
- reg_write, mem_read, mem_write, branch, jump, illegal  out  1 each  control flags

## Operation
- Decode is combinational on inst. The result plus pc_in is pushed into the queue when in_valid && in_ready.
- Outputs always show the queue head. Pop on out_valid && out_ready.
- R-type (0110011): src_tag 110, reg_write 1. alu_op is taken from {funct7,funct3}. An unlisted funct7 gives illegal.
- I-ALU (0010011): src_tag 011. SLLI/SRLI/SRAI require funct7 0000000/0000000/0100000, otherwise illegal.
- Load (0000011): ADD, src 011, mem_read, reg_write.
- Store (0100011): ADD, src 111, mem_write.
- Branch (1100011): SUB, src 110, branch. funct3 values 010/011 give illegal.
- LUI: ADD, src 001, rs1 forced to 0.
- AUIPC: ADD, src 001. JAL: jump, src 001. JALR: jump, src 011. All three set reg_write.
- Immediates:
  - I: inst[31:20]
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - All are sign-extended to XLEN.
- Fields a format does not use output 0.
- An illegal instruction pushes with inst_type 7, alu_op NOP, and all control flags 0 except illegal.
- rd=0 forces reg_write 0.

## Timing
- Reset, applied asynchronously: queue empty, out_valid 0, in_ready 1. All payload outputs are 0.
- Latency: an instruction accepted at edge N is at the head at N+1 if the queue was empty.
- in_ready = !full, registered. There is no combinational path from out_ready to in_ready.
- When full, a simultaneous pop does not allow a push that cycle; in_ready stays 0 until the next edge. DEPTH=2 sustains one instruction per cycle.
- Pointers wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits distinguishes full from empty.
- Simultaneous push and pop when neither empty nor full: count is unchanged and both pointers advance.
- flush has priority over push and pop: the queue is empty next cycle and the accepted input is dropped.
- Payload holds stable while out_valid && !out_ready.
- Reset asserted mid-stream discards all entries immediately.

## Configuration
- ID_DECODE_MEXT_EN: when defined, R-type funct7=0000001 decodes to MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23, with src 110 and reg_write 1.
- When undefined, those encodings are illegal.

## Test plan
- Reset, then inst 0xFFF00093 (ADDI x1,x0,-1) -> next cycle out_valid 1, type 1, alu 1, imm 0xFFFFFFFF, rd 1, src 011, reg_write 1.
- 0x402081B3 (SUB x3,x1,x2) -> alu 2, rs1 1, rs2 2, rd 3, src 110. 0x0020A423 (SW x2,8(x1)) -> type 2, imm 8, mem_write 1, reg_write 0.
- 0x027302B3 (MUL x5,x6,x7) -> alu 16 with ID_DECODE_MEXT_EN; without it type 7, illegal 1, reg_write 0.
- Hold out_ready 0 and stream 3 instructions with DEPTH=2 -> in_ready drops after 2 accepts, head payload stable. Release out_ready -> order preserved, no loss or duplicates.
- Queue holds 2 entries; assert flush together with in_valid -> next cycle out_valid 0, in_ready 1, pushed instruction dropped.
- Random back-to-back stream with random out_ready at DEPTH 2 and 4 -> output sequence equals the accepted input sequence, checked against a reference decode model.
